paula_audio_mixer_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4-channel Paula stereo mixer.
- On each sample strobe it snapshots N channel samples, volumes and per-channel stereo routing.
- It then accumulates sample×volume products through one shared multiplier, one channel per clk7_en cycle.
- It finishes by publishing saturated left/right sums with a one-cycle valid pulse. It sits between the Paula audio channel state machines and the audio DAC/filter path.

---
 rtl/paula_audio_mixer_seq.sv | 178 +++++++++++++++++
 tb/tb_paula_audio_mixer_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/paula_audio_mixer_seq.sv
// Time-multiplexed stereo audio mixer: snapshots NCH channels on a strobe,
// accumulates sample x volume through one shared multiplier, one channel per
// clk7_en cycle, then publishes saturated left/right sums with a valid pulse.
//
// state | meaning
// IDLE  | waiting for strobe; outputs hold the last published mix
// ACC   | accumulating channel idx into the left/right accumulators
// OUT   | saturate accumulators, publish outputs, pulse valid
module paula_audio_mixer_seq #(
  parameter int NCH   = 4,
  parameter int SW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk7_en,
  input  logic              strobe,
  input  logic [NCH*SW-1:0] sample,
  input  logic [NCH*7-1:0]  vol,
  input  logic [NCH*2-1:0]  route,
  output logic [OW-1:0]     ldatasum,
  output logic [OW-1:0]     rdatasum,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = SW + 8 + $clog2(NCH);
  // Saturation compare width; covers the case OW >= AW without truncation.
  localparam int XW = (AW > OW) ? AW : OW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NCH*SW-1:0]      sample_sh_q, sample_sh_d;
  logic [NCH*7-1:0]       vol_sh_q, vol_sh_d;
  logic [NCH*2-1:0]       route_sh_q, route_sh_d;
  logic signed [AW-1:0]   acc_l_q, acc_l_d;
  logic signed [AW-1:0]   acc_r_q, acc_r_d;
  logic [OW-1:0]          ldatasum_q, ldatasum_d;
  logic [OW-1:0]          rdatasum_q, rdatasum_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic [SW-1:0]          samp_cur;
  logic [6:0]             vol_cur;
  logic [1:0]             route_cur;
  logic [6:0]             ev;
  logic signed [AW-1:0]   prod;
  logic signed [AW-1:0]   acc_l_sh, acc_r_sh;
  logic signed [XW-1:0]   ext_l, ext_r;

  // Clamp a sign-extended accumulator into the signed OW-bit output range.
  function automatic logic [OW-1:0] sat(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = '0;
    hi[OW-2:0] = '1;
    lo = '1;
    lo[OW-2:0] = '0;
    if (x > hi)
      sat = hi[OW-1:0];
    else if (x < lo)
      sat = lo[OW-1:0];
    else
      sat = x[OW-1:0];
  endfunction

  // Shared multiplier: current channel's sample times its effective volume.
  always_comb begin
    samp_cur  = sample_sh_q[idx_q*SW +: SW];
    vol_cur   = vol_sh_q[idx_q*7 +: 7];
    route_cur = route_sh_q[idx_q*2 +: 2];
    // vol[6] means exact unity gain (64), ignoring the low bits.
    ev        = vol_cur[6] ? 7'd64 : {1'b0, vol_cur[5:0]};
    prod      = {{(AW-SW){samp_cur[SW-1]}}, samp_cur} * {{(AW-7){1'b0}}, ev};
    acc_l_sh  = acc_l_q >>> SHIFT;
    acc_r_sh  = acc_r_q >>> SHIFT;
    ext_l     = XW'(acc_l_sh);
    ext_r     = XW'(acc_r_sh);
  end

  // Next-state and datapath updates; nothing advances without clk7_en.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sample_sh_d = sample_sh_q;
    vol_sh_d    = vol_sh_q;
    route_sh_d  = route_sh_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    ldatasum_d  = ldatasum_q;
    rdatasum_d  = rdatasum_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    if (clk7_en) begin
      case (state_q)
        IDLE: begin
          if (strobe) begin
            sample_sh_d = sample;
            vol_sh_d    = vol;
            route_sh_d  = route;
            acc_l_d     = '0;
            acc_r_d     = '0;
            idx_d       = '0;
            state_d     = ACC;
          end
        end
        ACC: begin
          overrun_d = strobe;
          if (route_cur[1])
            acc_l_d = acc_l_q + prod;
          if (route_cur[0])
            acc_r_d = acc_r_q + prod;
          if (idx_q == IW'(NCH-1)) begin
            idx_d   = '0;
            state_d = OUT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        OUT: begin
          overrun_d  = strobe;
          ldatasum_d = sat(ext_l);
          rdatasum_d = sat(ext_r);
          valid_d    = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any mix in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sample_sh_q <= '0;
      vol_sh_q    <= '0;
      route_sh_q  <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      ldatasum_q  <= '0;
      rdatasum_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sample_sh_q <= sample_sh_d;
      vol_sh_q    <= vol_sh_d;
      route_sh_q  <= route_sh_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      ldatasum_q  <= ldatasum_d;
      rdatasum_q  <= rdatasum_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ldatasum = ldatasum_q;
  assign rdatasum = rdatasum_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == ACC) || (state_q == OUT);

endmodule

// File: tb/tb_paula_audio_mixer_seq.sv
// Scoreboard bench for paula_audio_mixer_seq: a default instance (OW=16) and a
// saturation instance (OW=14) share inputs but have separate strobes.
module tb_paula_audio_mixer_seq;

  logic               clk;
  logic               reset_n;
  logic               clk7_en;
  logic               strobe;
  logic               strobe_s;
  logic [31:0]        sample;
  logic [27:0]        vol;
  logic [7:0]         route;
  logic signed [15:0] ldatasum, rdatasum;
  logic               valid, busy, overrun;
  logic signed [13:0] ldatasum_s, rdatasum_s;
  logic               valid_s, busy_s, overrun_s;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int novr   = 0;
  int exp_l[$];
  int exp_r[$];
  int exp_ls[$];
  int exp_rs[$];
  longint vtimes[$];

  paula_audio_mixer_seq dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .strobe(strobe),
    .sample(sample), .vol(vol), .route(route),
    .ldatasum(ldatasum), .rdatasum(rdatasum),
    .valid(valid), .busy(busy), .overrun(overrun)
  );

  paula_audio_mixer_seq #(.OW(14)) dut_s (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .strobe(strobe_s),
    .sample(sample), .vol(vol), .route(route),
    .ldatasum(ldatasum_s), .rdatasum(rdatasum_s),
    .valid(valid_s), .busy(busy_s), .overrun(overrun_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever either instance presents valid.
  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      vtimes.push_back($time);
      if (exp_l.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("ldatasum", ldatasum, exp_l.pop_front());
        check("rdatasum", rdatasum, exp_r.pop_front());
      end
    end
    if (overrun) novr++;
    if (valid_s) begin
      if (exp_ls.size() == 0) begin
        check("unexpected_valid_sat", 1, 0);
      end else begin
        check("ldatasum_sat", ldatasum_s, exp_ls.pop_front());
        check("rdatasum_sat", rdatasum_s, exp_rs.pop_front());
      end
    end
  end

  task automatic wait_valid(input bit sel, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel ? valid_s : valid) begin
        n = i;
        return;
      end
    end
  endtask

  // One mix with clk7_en held high; optional input corruption after the snapshot.
  task automatic run_mix(input bit sel, input logic [31:0] s, input logic [27:0] v,
                         input logic [7:0] r, input int el, input int er, input bit corrupt);
    int n;
    sample = s;
    vol    = v;
    route  = r;
    if (sel) begin
      exp_ls.push_back(el);
      exp_rs.push_back(er);
      strobe_s = 1'b1;
    end else begin
      exp_l.push_back(el);
      exp_r.push_back(er);
      strobe = 1'b1;
    end
    tick();
    strobe   = 1'b0;
    strobe_s = 1'b0;
    check("busy_after_strobe", sel ? busy_s : busy, 1);
    if (corrupt) begin
      sample = {4{8'h7F}};
      vol    = {4{7'h40}};
      route  = 8'hFF;
    end
    wait_valid(sel, n);
    check("latency", n, 5);
    tick();
    check("valid_one_clk", sel ? valid_s : valid, 0);
    check("busy_idle", sel ? busy_s : busy, 0);
  endtask

  initial begin
    int nv0, no0;
    reset_n  = 1'b0;
    clk7_en  = 1'b0;
    strobe   = 1'b0;
    strobe_s = 1'b0;
    sample   = '0;
    vol      = '0;
    route    = '0;
    repeat (3) tick();
    check("rst_ldatasum", ldatasum, 0);
    check("rst_rdatasum", rdatasum, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    clk7_en = 1'b1;
    tick();

    // Paula-style routing: ch0/ch3 right (01), ch1/ch2 left (10).
    run_mix(0, {8'h7F, 8'hF0, 8'h20, 8'h10}, {4{7'h40}}, 8'b01_10_10_01, 1024, 9152, 0);

    // Reset mid-mix: abandon, outputs cleared, no valid pulse.
    nv0 = nvalid;
    sample = {8'h7F, 8'hF0, 8'h20, 8'h10};
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_ldatasum", ldatasum, 0);
    check("midrst_rdatasum", rdatasum, 0);
    check("midrst_busy", busy, 0);
    repeat (6) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("midrst_no_valid", nvalid - nv0, 0);

    // Volume and mute: ch0 -128 x 63 both sides, ch1 muted at unity, others vol 0.
    run_mix(0, {8'h7F, 8'h7F, 8'h55, 8'h80}, {7'h00, 7'h00, 7'h7F, 7'h3F},
            8'b11_11_00_11, -8064, -8064, 0);
    // Full-scale extremes on the default instance never saturate.
    run_mix(0, {4{8'h7F}}, {4{7'h40}}, 8'hFF, 32512, 32512, 0);
    run_mix(0, {4{8'h80}}, {4{7'h40}}, 8'hFF, -32768, -32768, 0);
    // Snapshot isolation: inputs change during ACC.
    run_mix(0, {8'h7F, 8'hF0, 8'h20, 8'h10}, {4{7'h40}}, 8'b01_10_10_01, 1024, 9152, 1);
    // Saturation at OW=14.
    run_mix(1, {4{8'h7F}}, {4{7'h40}}, 8'hFF, 8191, 8191, 0);
    run_mix(1, {4{8'h80}}, {4{7'h40}}, 8'hFF, -8192, -8192, 0);

    // Enable gating 1-in-4 with strobe held: 18 enables give 3 mixes, 15 overruns.
    sample = {8'h7F, 8'hF0, 8'h20, 8'h10};
    vol    = {4{7'h40}};
    route  = 8'b01_10_10_01;
    repeat (3) begin
      exp_l.push_back(1024);
      exp_r.push_back(9152);
    end
    nv0 = nvalid;
    no0 = novr;
    vtimes.delete();
    strobe = 1'b1;
    for (int i = 0; i < 72; i++) begin
      clk7_en = (i % 4 == 0);
      tick();
    end
    strobe  = 1'b0;
    clk7_en = 1'b1;
    repeat (4) tick();
    check("gated_valid_count", nvalid - nv0, 3);
    check("gated_overrun_count", novr - no0, 15);
    if (vtimes.size() >= 3) begin
      check("gated_valid_spacing_a", int'(vtimes[1] - vtimes[0]), 240);
      check("gated_valid_spacing_b", int'(vtimes[2] - vtimes[1]), 240);
    end

    repeat (10) tick();
    check("scoreboard_drained", exp_l.size() + exp_ls.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
